// File: rtl/axi_wdata_streamer.sv
// AXI4 W-channel streamer: pops pre-aligned words from the writer FIFO and issues W beats with
// per-beat strobes and WLAST at burst boundaries (max-length and 4KB splits).
module axi_wdata_streamer #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned BTT_WIDTH     = 20,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_write_start_addr,
    input  logic [BTT_WIDTH-1:0]    i_btt,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_fifo_read,
    input  logic [DATA_WIDTH-1:0]   i_fifo_data,
    input  logic                    i_fifo_empty,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast
);

    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS   = $clog2(BYTES);
    localparam int unsigned CW         = BTT_WIDTH + 1;
    localparam int unsigned PAGE_BEATS = 4096 / BYTES;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [BYTES-1:0] ONES = '1;

    logic [1:0]            state;
    logic [OFF_BITS-1:0]   off_q;
    logic [OFF_BITS-1:0]   end_off_q;
    logic [CW-1:0]         total_beats;
    logic [CW-1:0]         pops_left;
    logic [CW-1:0]         sends_left;
    logic [CW-1:0]         burst_rem;
    logic [ADDR_WIDTH-1:0] beat_addr;

    logic [CW-1:0]         start_sum;
    logic [CW-1:0]         start_beats;
    logic [12:0]           page_left;
    logic [CW-1:0]         new_len;
    logic [CW-1:0]         burst_len;
    logic                  w_hs;
    logic                  is_first;
    logic                  is_last;
    logic [BYTES-1:0]      first_mask;
    logic [BYTES-1:0]      last_mask;
    logic [BYTES-1:0]      beat_strb;

    assign start_sum   = CW'(i_write_start_addr[OFF_BITS-1:0]) + CW'(i_btt);
    assign start_beats = (start_sum + CW'(BYTES - 1)) >> OFF_BITS;

    assign w_hs        = o_wvalid & i_wready;
    assign o_fifo_read = (state == RUN) & ~i_fifo_empty & (pops_left != '0) &
                         (~o_wvalid | i_wready);
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);

    // Beats left before the next 4KB page, counted from the current aligned beat address.
    assign page_left = 13'(PAGE_BEATS) - 13'(beat_addr[11:OFF_BITS]);

    always_comb begin
        new_len = CW'(MAX_BURST_LEN);
        if (pops_left < new_len) new_len = pops_left;
        if (CW'(page_left) < new_len) new_len = CW'(page_left);
    end

    // burst_rem == 0 means the beat about to pop opens a new burst.
    assign burst_len = (burst_rem == '0) ? new_len : burst_rem;

    assign is_first   = (pops_left == total_beats);
    assign is_last    = (pops_left == CW'(1));
    assign first_mask = ONES << off_q;
    assign last_mask  = (end_off_q == '0) ? ONES : ~(ONES << end_off_q);
    assign beat_strb  = (is_first ? first_mask : ONES) & (is_last ? last_mask : ONES);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            off_q       <= '0;
            end_off_q   <= '0;
            total_beats <= '0;
            pops_left   <= '0;
            sends_left  <= '0;
            burst_rem   <= '0;
            beat_addr   <= '0;
            o_wvalid    <= 1'b0;
            o_wdata     <= '0;
            o_wstrb     <= '0;
            o_wlast     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        off_q       <= i_write_start_addr[OFF_BITS-1:0];
                        end_off_q   <= start_sum[OFF_BITS-1:0];
                        total_beats <= start_beats;
                        pops_left   <= start_beats;
                        sends_left  <= start_beats;
                        burst_rem   <= '0;
                        beat_addr   <= {i_write_start_addr[ADDR_WIDTH-1:OFF_BITS],
                                        {OFF_BITS{1'b0}}};
                        state       <= (i_btt == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_hs && sends_left == CW'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (w_hs) sends_left <= sends_left - CW'(1);

            if (o_fifo_read) begin
                pops_left <= pops_left - CW'(1);
                beat_addr <= beat_addr + ADDR_WIDTH'(BYTES);
                burst_rem <= burst_len - CW'(1);
                o_wvalid  <= 1'b1;
                o_wdata   <= i_fifo_data;
                o_wstrb   <= beat_strb;
                o_wlast   <= (burst_len == CW'(1));
            end else if (w_hs) begin
                o_wvalid  <= 1'b0;
            end
        end
    end

endmodule
